// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: NOP encoding, fetch FSM states and the IF/ID record.
package mips_pkg;

  localparam logic [31:0] MIPS_NOP   = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [31:0] WORD_BYTES = 32'd4;

  typedef enum logic {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bundle: hazard/branch controls, instruction-memory port and IF/ID outputs.
interface if_fetch_stage_if #(
  parameter int PC_W    = 32,
  parameter int IMEM_AW = 5
);
  logic               stall_i;
  logic               flush_i;
  logic [PC_W-1:0]    branch_target_i;
  logic [IMEM_AW-1:0] imem_addr_o;
  logic [31:0]        imem_rdata_i;
  logic [PC_W-1:0]    pc_o;
  logic [31:0]        ifid_inst_o;
  logic [PC_W-1:0]    ifid_pc4_o;
  logic               ifid_valid_o;

  modport master (
    input  stall_i, flush_i, branch_target_i, imem_rdata_i,
    output imem_addr_o, pc_o, ifid_inst_o, ifid_pc4_o, ifid_valid_o
  );

  modport slave (
    output stall_i, flush_i, branch_target_i, imem_rdata_i,
    input  imem_addr_o, pc_o, ifid_inst_o, ifid_pc4_o, ifid_valid_o
  );
endinterface

// File: rtl/ifid_reg.sv
// Generic pipeline stage register with hold (stall) and clear (bubble) controls.
module ifid_reg #(
  parameter int           W       = 1,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         hold,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] data_q;

  // Clear outranks hold so a squash always lands even while stalled.
  always_ff @(posedge clk) begin
    if (srst || clear) begin
      data_q <= CLR_VAL;
    end else if (!hold) begin
      data_q <= d;
    end
  end

  assign q = data_q;
endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC, boot bubble, stall/flush handling and IF/ID register.
// Optional performance counters are enabled by defining IF_FETCH_PERF_EN.
module if_fetch_stage
  import mips_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              IMEM_AW  = 5,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_INST = MIPS_NOP
) (
  input  logic                     clk,
  input  logic                     rst,
  if_fetch_stage_if.master         bus
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]              perf_fetch_cnt_o,
  output logic [31:0]              perf_stall_cnt_o,
  output logic [31:0]              perf_flush_cnt_o
`endif
);
  localparam int IFID_W = 32 + PC_W + 1;
  localparam logic [IFID_W-1:0] IFID_BUBBLE = {NOP_INST, {PC_W{1'b0}}, 1'b0};

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_plus4;
  logic            ifid_hold, ifid_clear;
  logic            ev_fetch, ev_stall, ev_flush;
  logic [IFID_W-1:0] ifid_d, ifid_q;

  assign pc_plus4 = pc_q + PC_W'(WORD_BYTES);

  always_comb begin
    state_d    = S_RUN;
    pc_d       = pc_q;
    ifid_hold  = 1'b0;
    ifid_clear = 1'b0;
    ev_fetch   = 1'b0;
    ev_stall   = 1'b0;
    ev_flush   = 1'b0;
    case (state_q)
      S_BOOT: begin
        ifid_clear = 1'b1;
      end
      S_RUN: begin
        if (bus.flush_i) begin
          pc_d       = {bus.branch_target_i[PC_W-1:2], 2'b00};
          ifid_clear = 1'b1;
          ev_flush   = 1'b1;
        end else if (bus.stall_i) begin
          ifid_hold = 1'b1;
          ev_stall  = 1'b1;
        end else begin
          pc_d     = pc_plus4;
          ev_fetch = 1'b1;
        end
      end
      default: begin
        ifid_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign ifid_d = {bus.imem_rdata_i, pc_plus4, 1'b1};

  ifid_reg #(
    .W       (IFID_W),
    .CLR_VAL (IFID_BUBBLE)
  ) u_ifid (
    .clk   (clk),
    .srst  (rst),
    .hold  (ifid_hold),
    .clear (ifid_clear),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign bus.pc_o         = pc_q;
  assign bus.imem_addr_o  = pc_q[IMEM_AW-1:0];
  assign bus.ifid_inst_o  = ifid_q[IFID_W-1 -: 32];
  assign bus.ifid_pc4_o   = ifid_q[PC_W:1];
  assign bus.ifid_valid_o = ifid_q[0];

`ifdef IF_FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (ev_fetch) fetch_cnt_q <= sat_inc32(fetch_cnt_q);
      if (ev_stall) stall_cnt_q <= sat_inc32(stall_cnt_q);
      if (ev_flush) flush_cnt_q <= sat_inc32(flush_cnt_q);
    end
  end

  assign perf_fetch_cnt_o = fetch_cnt_q;
  assign perf_stall_cnt_o = stall_cnt_q;
  assign perf_flush_cnt_o = flush_cnt_q;
`endif
endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: spec-level model compared every cycle plus literal checkpoints.
`timescale 1ns/1ps
module tb_if_fetch_stage;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  if_fetch_stage_if #(.PC_W(32), .IMEM_AW(5)) bus ();

`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetch, perf_stall, perf_flush;
`endif

  if_fetch_stage #(
    .PC_W(32), .IMEM_AW(5), .RESET_PC(32'h0), .NOP_INST(32'h0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
`ifdef IF_FETCH_PERF_EN
    ,
    .perf_fetch_cnt_o (perf_fetch),
    .perf_stall_cnt_o (perf_stall),
    .perf_flush_cnt_o (perf_flush)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] mem [8];
  initial for (int i = 0; i < 8; i++) mem[i] = 32'hA000_0000 + 32'(i);
  assign bus.imem_rdata_i = mem[bus.imem_addr_o[4:2]];

  // Model: fetch state described directly by the architectural rules.
  logic  m_booting;
  logic [31:0] m_pc;
  ifid_t m_ifid;
  logic  m_ok = 1'b0;
  longint m_fetch, m_stall, m_flush;

  always @(posedge clk) begin
    if (rst) begin
      m_pc = 32'h0; m_ifid = '{32'h0, 32'h0, 1'b0};
      m_booting = 1'b1; m_ok = 1'b1;
      m_fetch = 0; m_stall = 0; m_flush = 0;
    end else if (m_ok) begin
      if (m_booting) begin
        m_ifid = '{32'h0, 32'h0, 1'b0};
        m_booting = 1'b0;
      end else if (bus.flush_i) begin
        m_pc = bus.branch_target_i & ~32'h3;
        m_ifid = '{32'h0, 32'h0, 1'b0};
        m_flush++;
      end else if (bus.stall_i) begin
        m_stall++;
      end else begin
        m_ifid = '{mem[(m_pc % 32) / 4], m_pc + 32'd4, 1'b1};
        m_pc = m_pc + 32'd4;
        m_fetch++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_ok) begin
      chk("model.pc", bus.pc_o, m_pc);
      chk("model.imem_addr", {27'd0, bus.imem_addr_o}, m_pc % 32);
      chk("model.inst", bus.ifid_inst_o, m_ifid.inst);
      chk("model.pc4", bus.ifid_pc4_o, m_ifid.pc4);
      chk("model.valid", {31'd0, bus.ifid_valid_o}, {31'd0, m_ifid.valid});
`ifdef IF_FETCH_PERF_EN
      chk("model.perf_fetch", perf_fetch, 32'(m_fetch));
      chk("model.perf_stall", perf_stall, 32'(m_stall));
      chk("model.perf_flush", perf_flush, 32'(m_flush));
`endif
    end
  end

  task automatic step(input logic r, input logic s, input logic f, input logic [31:0] t);
    @(negedge clk);
    rst = r; bus.stall_i = s; bus.flush_i = f; bus.branch_target_i = t;
    @(posedge clk);
    #1;
    $display("[TB] rst=%0b stall=%0b flush=%0b tgt=%h -> pc=%h inst=%h pc4=%h v=%0b",
             r, s, f, t, bus.pc_o, bus.ifid_inst_o, bus.ifid_pc4_o, bus.ifid_valid_o);
  endtask

  task automatic pin(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                     input logic [31:0] pc4, input logic v);
    chk({tag, ".pc"}, bus.pc_o, pc);
    chk({tag, ".inst"}, bus.ifid_inst_o, inst);
    chk({tag, ".pc4"}, bus.ifid_pc4_o, pc4);
    chk({tag, ".valid"}, {31'd0, bus.ifid_valid_o}, {31'd0, v});
  endtask

  initial begin
    rst = 1'b1; bus.stall_i = 1'b0; bus.flush_i = 1'b0; bus.branch_target_i = '0;
    step(1, 0, 0, 0);            pin("reset", 0, 0, 0, 0);
    step(0, 0, 0, 0);            pin("boot", 0, 0, 0, 0);
    step(0, 0, 0, 0);            pin("run0", 4, 32'hA000_0000, 4, 1);
    step(0, 0, 0, 0);            pin("run1", 8, 32'hA000_0001, 8, 1);
    step(0, 1, 0, 0);            pin("stall1", 8, 32'hA000_0001, 8, 1);
    step(0, 1, 0, 0);            pin("stall2", 8, 32'hA000_0001, 8, 1);
    step(0, 0, 0, 0);            pin("after_stall", 12, 32'hA000_0002, 12, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);            pin("run4", 20, 32'hA000_0004, 20, 1);
    step(0, 0, 1, 0);            pin("flush0", 0, 0, 0, 0);
    step(0, 0, 0, 0);            pin("after_flush", 4, 32'hA000_0000, 4, 1);
    step(0, 1, 1, 32'h10);       pin("flush_beats_stall", 16, 0, 0, 0);
    step(0, 0, 1, 32'd28);       pin("flush28", 28, 0, 0, 0);
    step(0, 0, 0, 0);            pin("wrap_fetch", 32, 32'hA000_0007, 32, 1);
    chk("wrap_addr", {27'd0, bus.imem_addr_o}, 32'd0);
    step(0, 0, 1, 32'hFFFF_FFFC); pin("top_target", 32'hFFFF_FFFC, 0, 0, 0);
    step(0, 0, 0, 0);            pin("pc_wrap", 0, 32'hA000_0007, 0, 1);
    step(0, 0, 1, 32'h6);        pin("misaligned", 4, 0, 0, 0);
    step(0, 0, 0, 0);            pin("mis_fetch", 8, 32'hA000_0001, 8, 1);
    step(0, 0, 0, 0);            pin("pc12", 12, 32'hA000_0002, 12, 1);
    step(0, 1, 0, 0);            pin("stall12", 12, 32'hA000_0002, 12, 1);
    step(1, 1, 1, 32'h18);       pin("rst_mid_stall", 0, 0, 0, 0);
`ifdef IF_FETCH_PERF_EN
    chk("perf_fetch_rst", perf_fetch, 0);
    chk("perf_stall_rst", perf_stall, 0);
    chk("perf_flush_rst", perf_flush, 0);
`endif
    step(0, 1, 1, 32'h10);       pin("boot_ignores", 0, 0, 0, 0);
    step(0, 0, 0, 0);            pin("reboot_run0", 4, 32'hA000_0000, 4, 1);
    step(0, 0, 0, 0);            pin("reboot_run1", 8, 32'hA000_0001, 8, 1);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
